// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared pipeline definitions for the RV32I front end: the architectural NOP
// used for bubbles and flushes, the default reset fetch address, and the
// fetch-stage state encoding.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0013;

  // First fetch address after reset.
  localparam logic [31:0] PIPE_RESET_PC  = 32'h0000_0000;

  // FETCH: normal operation.
  // DROP : a redirect arrived while a request was still waiting; that request
  //        must finish on the bus, but its data is thrown away.
  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// -----------------------------------------------------------------------------
// ifid_reg
// IF/ID pipeline register with reset > flush > stall > load > bubble priority.
// The same pattern serves for the ID/EX register.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_flush        replace contents with NOP, valid cleared
//   i_stall        hold contents
//   i_load         capture i_instr/i_pc/i_pc_plus4 as a valid instruction
//   i_instr        instruction to capture
//   i_pc           PC of that instruction
//   i_pc_plus4     PC + 4 of that instruction
//   o_instr        registered instruction (NOP when not valid)
//   o_pc           registered PC
//   o_pc_plus4     registered PC + 4
//   o_valid        register holds a real instruction
// -----------------------------------------------------------------------------
module ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter int unsigned       XLEN      = 32,
  parameter logic [31:0]       NOP_INSTR = PIPE_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_stall,
  input  logic            i_load,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_plus4,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_valid
);

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load && !i_stall) begin
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end else if (!i_stall) begin
      // Bubble: PC fields keep their last value.
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// IF stage of the 5-stage RV32I pipeline. Owns the fetch PC, runs a single
// outstanding request/ready transaction to instruction memory, and produces
// the IF/ID register. Memory wait states appear downstream as bubbles.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   stallF         hold PC, start no new request
//   stallD         hold IF/ID
//   flushD         clear IF/ID (driven together with pc_srcE)
//   pc_srcE        redirect taken in execute
//   pc_targetE     redirect target (low two bits ignored)
//   imem_req       request valid
//   imem_addr      request address, word aligned
//   imem_rdata     instruction, valid when imem_req & imem_ready
//   imem_ready     completes the current request this cycle
//   instrD         IF/ID instruction
//   pcD            IF/ID PC
//   pc_plus4D      IF/ID PC + 4
//   validD         IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(PIPE_RESET_PC),
  parameter logic [31:0]      NOP_INSTR = PIPE_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            flushD,
  input  logic            pc_srcE,
  input  logic [XLEN-1:0] pc_targetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic [31:0]     instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc_plus4D,
  output logic            validD
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [XLEN-1:0] r_pc_f;
  logic [XLEN-1:0] r_pending_pc;
  logic            r_req_active;
  logic            r_buf_valid;
  logic [31:0]     r_buf_instr;
  logic [XLEN-1:0] r_buf_pc;

  logic            w_req;
  logic            w_complete;
  logic            w_open_wait;
  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_d_load;
  logic [31:0]     w_d_instr;
  logic [XLEN-1:0] w_d_pc;

  assign w_complete  = w_req & imem_ready;
  // A request is on the bus but will not finish this cycle; it must be held.
  assign w_open_wait = w_req & ~imem_ready;
  // flushD and pc_srcE are the same event seen from two sides.
  assign w_redirect  = pc_srcE | flushD;
  assign w_target    = pc_targetE & ~XLEN'(3);
  assign w_pc_plus4  = r_pc_f + XLEN'(4);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    if (w_redirect) begin
      w_state_next = w_open_wait ? DROP : FETCH;
    end else if (r_state == DROP && w_complete) begin
      w_state_next = FETCH;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_req = 1'b0;
    if (!rst) begin
      case (r_state)
        // An open request must stay up even if stallF rises meanwhile.
        FETCH:   w_req = ~r_buf_valid & (~stallF | r_req_active);
        DROP:    w_req = 1'b1;
        default: w_req = 1'b0;
      endcase
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc_f;

  // ---------------------------------------------------------------------------
  // Fetch PC, pending redirect, transaction tracking, buffer valid
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_f       <= RESET_PC;
      r_pending_pc <= RESET_PC;
      r_req_active <= 1'b0;
      r_buf_valid  <= 1'b0;
    end else begin
      r_req_active <= w_open_wait;
      if (w_redirect) begin
        r_buf_valid <= 1'b0;
        if (w_open_wait) r_pending_pc <= w_target;
        else             r_pc_f       <= w_target;
      end else if (r_state == DROP) begin
        if (w_complete) r_pc_f <= r_pending_pc;
      end else begin
        if (w_complete) r_pc_f <= w_pc_plus4;
        // A completion during stallD parks in the buffer; a free D drains it.
        if (stallD) begin
          if (w_complete) r_buf_valid <= 1'b1;
        end else begin
          r_buf_valid <= 1'b0;
        end
      end
    end
  end

  // NOTE: the buffer payload has no reset; r_buf_valid qualifies it, so
  // resetting the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (!w_redirect && r_state == FETCH && stallD && w_complete) begin
      r_buf_instr <= imem_rdata;
      r_buf_pc    <= r_pc_f;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID register. Buffered data has priority; a completion can only occur
  // when the buffer is empty because no request is made while it is full.
  // ---------------------------------------------------------------------------
  assign w_d_load  = r_buf_valid | (r_state == FETCH && w_complete);
  assign w_d_instr = r_buf_valid ? r_buf_instr : imem_rdata;
  assign w_d_pc    = r_buf_valid ? r_buf_pc    : r_pc_f;

  ifid_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (w_redirect),
    .i_stall    (stallD),
    .i_load     (w_d_load),
    .i_instr    (w_d_instr),
    .i_pc       (w_d_pc),
    .i_pc_plus4 (w_d_pc + XLEN'(4)),
    .o_instr    (instrD),
    .o_pc       (pcD),
    .o_pc_plus4 (pc_plus4D),
    .o_valid    (validD)
  );

endmodule
